alert_arbiter: RTL

//  Round-robin scheduler for home-automation alert events. Latches rising edges of six

---
 rtl/alert_arbiter_if.sv | 13 +
 rtl/alert_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alert_arbiter_if.sv
// Grant bus between the alert arbiter and the actuator/display unit.
// The arbiter drives valid/display/act/pending/drop; downstream answers with ack.
interface alert_arbiter_if;
  logic       valid;
  logic       ack;
  logic [2:0] display;
  logic [5:0] act;
  logic [5:0] pending;
  logic       drop;

  modport master (output valid, display, act, pending, drop, input ack);
  modport slave  (input valid, display, act, pending, drop, output ack);
endinterface

// File: rtl/alert_arbiter.sv
// Round-robin alert arbiter: latches sensor rising edges and grants them one at a time.
// Optional macro FIRE_PREEMPT_EN gives fire absolute priority and lets it abort other grants.
module alert_arbiter #(
  parameter logic [6:0] T_LOW    = 7'd50,
  parameter logic [6:0] T_HIGH   = 7'd70,
  parameter int         HOLD_CYC = 4,
  parameter int         ACK_TO   = 8,
  parameter int         CNT_W    = 4
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            SFD,
  input  logic            SRD,
  input  logic            SFA,
  input  logic            SW,
  input  logic [6:0]      ST,
  alert_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t           state, state_n;
  logic [2:0]       ptr, ptr_n;
  logic [2:0]       sel, sel_n;
  logic [2:0]       sel_inc;
  logic [CNT_W-1:0] counter, counter_n;
  logic             valid_q, valid_n;
  logic [2:0]       display_q, display_n;
  logic [5:0]       act_q, act_n;
  logic             drop_q, drop_n;
  logic [5:0]       cond, cond_q, rise;
  logic [5:0]       pending_q, clr;
  logic             abort;

  assign cond    = {ST > T_HIGH, ST < T_LOW, SW, SFA, SRD, SFD};
  assign rise    = cond & ~cond_q;
  assign sel_inc = (sel == 3'd5) ? 3'd0 : sel + 3'd1;

  // First set bit at or after start, wrapping modulo six.
  function automatic logic [2:0] pick(input logic [5:0] p, input logic [2:0] start);
    int   j;
    logic found;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < 6; k++) begin
      j = int'(start) + k;
      if (j >= 6) j = j - 6;
      if (!found && p[j]) begin
        pick  = 3'(j);
        found = 1'b1;
      end
    end
  endfunction

  always_ff @(negedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      sel       <= 3'd0;
      counter   <= '0;
      valid_q   <= 1'b0;
      display_q <= 3'd0;
      act_q     <= 6'd0;
      drop_q    <= 1'b0;
      cond_q    <= 6'd0;
      pending_q <= 6'd0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      sel       <= sel_n;
      counter   <= counter_n;
      valid_q   <= valid_n;
      display_q <= display_n;
      act_q     <= act_n;
      drop_q    <= drop_n;
      cond_q    <= cond;
      // A new rise beats a completion clear of the same bit.
      pending_q <= (pending_q & ~clr) | rise;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    sel_n     = sel;
    counter_n = counter;
    valid_n   = valid_q;
    display_n = display_q;
    act_n     = act_q;
    drop_n    = 1'b0;
    clr       = 6'd0;
`ifdef FIRE_PREEMPT_EN
    abort     = (state != IDLE) && (sel != 3'd2) && pending_q[2];
`else
    abort     = 1'b0;
`endif

    if (abort) begin
      state_n   = IDLE;
      valid_n   = 1'b0;
      display_n = 3'd0;
      act_n     = 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pending_q != 6'd0) begin
`ifdef FIRE_PREEMPT_EN
            sel_n = pending_q[2] ? 3'd2 : pick(pending_q, ptr);
`else
            sel_n = pick(pending_q, ptr);
`endif
            state_n   = GRANT;
            valid_n   = 1'b1;
            display_n = sel_n + 3'd1;
            act_n     = 6'b100000 >> sel_n;
            counter_n = CNT_W'(ACK_TO - 1);
          end
        end
        GRANT: begin
          if (bus.ack) begin
            state_n   = HOLD;
            counter_n = CNT_W'(HOLD_CYC - 1);
          end else if (counter == '0) begin
            // Timed out: the event stays pending and the pointer moves past it.
            state_n   = IDLE;
            drop_n    = 1'b1;
            ptr_n     = sel_inc;
            valid_n   = 1'b0;
            display_n = 3'd0;
            act_n     = 6'd0;
          end else begin
            counter_n = counter - CNT_W'(1);
          end
        end
        HOLD: begin
          if (counter == '0) begin
            state_n   = IDLE;
            clr       = 6'(1) << sel;
            ptr_n     = sel_inc;
            valid_n   = 1'b0;
            display_n = 3'd0;
            act_n     = 6'd0;
          end else begin
            counter_n = counter - CNT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.valid   = valid_q;
  assign bus.display = display_q;
  assign bus.act     = act_q;
  assign bus.pending = pending_q;
  assign bus.drop    = drop_q;

endmodule
